// File: rtl/io_port_controller_pkg.sv
// Port map and STATUS byte layout shared by the I/O port controller files.
package io_port_controller_pkg;

  localparam logic [7:0] IO_PORT_TX     = 8'h00;
  localparam logic [7:0] IO_PORT_RX     = 8'h01;
  localparam logic [7:0] IO_PORT_STATUS = 8'h02;

  // Field order is the STATUS bit order, MSB first.
  typedef struct packed {
    logic       tx_ovf;
    logic       rx_unf;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_full;
    logic       rx_empty;
    logic [1:0] rsvd;
  } status_t;

  function automatic logic [7:0] status_byte(input logic tx_ovf, input logic rx_unf,
                                             input logic tx_full, input logic tx_empty,
                                             input logic rx_full, input logic rx_empty);
    status_t s;
    s = '{tx_ovf: tx_ovf, rx_unf: rx_unf, tx_full: tx_full, tx_empty: tx_empty,
          rx_full: rx_full, rx_empty: rx_empty, rsvd: 2'b00};
    return s;
  endfunction

endpackage

// File: rtl/io_port_controller_fifo.sv
// Byte FIFO with async reset; dout shows the head (00 when empty).
module io_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];

  // A pop in the same clk frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/tristate_buffer.sv
// Plain enable-controlled tristate driver.
module tristate_buffer #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  input  logic         en,
  output wire  [W-1:0] dout
);

  assign dout = en ? din : {W{1'bz}};

endmodule

// File: rtl/io_port_controller.sv
// Memory-mapped TX/RX/STATUS ports bridging the CPU bus to valid/ready byte streams.
module io_port_controller
  import io_port_controller_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr_bus,
  input  logic       mem_io,
  input  logic       io_wr,
  input  logic       io_rd,
  inout  wire  [7:0] bus,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       irq
);

  logic           io_wr_q, io_rd_q, drv_q, drv_d;
  logic           tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d, irq_q, irq_d;
  logic [7:0]     rd_hold_q, rd_hold_d, rx_dout;
  logic           wr_pulse, rd_pulse, sel_tx, sel_rx, sel_st;
  logic           tx_push, tx_pop, rx_push, rx_pop;
  logic           tx_full, tx_empty, rx_full, rx_empty, bus_en;
  logic [PTR_W:0] tx_count, rx_count;

  assign wr_pulse = io_wr & ~io_wr_q & mem_io;
  assign rd_pulse = io_rd & ~io_rd_q & mem_io;
  assign sel_tx   = (addr_bus == IO_PORT_TX);
  assign sel_rx   = (addr_bus == IO_PORT_RX);
  assign sel_st   = (addr_bus == IO_PORT_STATUS);

  assign tx_valid = (tx_count != '0);
  assign rx_ready = (rx_count != (PTR_W+1)'(DEPTH));
  assign tx_push  = wr_pulse & sel_tx;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd_pulse & sel_rx;
  assign irq      = irq_q;

  io_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(bus),
    .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  io_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_data),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    tx_ovf_d  = tx_ovf_q;
    rx_unf_d  = rx_unf_q;
    rd_hold_d = rd_hold_q;
    if (tx_push & tx_full & ~tx_pop) tx_ovf_d = 1'b1;
    if (wr_pulse & sel_st) begin
      tx_ovf_d = 1'b0;
      rx_unf_d = 1'b0;
    end
    if (rx_pop) begin
      rd_hold_d = rx_dout;
      if (rx_empty) rx_unf_d = 1'b1;
    end
    if (rd_pulse & sel_st)
      rd_hold_d = status_byte(tx_ovf_q, rx_unf_q, tx_full, tx_empty, rx_full, rx_empty);
    // Drive starts the clk after the read pulse and ends with the strobe.
    drv_d = drv_q & io_rd;
    if (rd_pulse & (sel_rx | sel_st)) drv_d = 1'b1;
    irq_d = ~rx_empty | tx_ovf_q | rx_unf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_wr_q   <= 1'b0;
      io_rd_q   <= 1'b0;
      drv_q     <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rx_unf_q  <= 1'b0;
      irq_q     <= 1'b0;
      rd_hold_q <= 8'h00;
    end else begin
      io_wr_q   <= io_wr;
      io_rd_q   <= io_rd;
      drv_q     <= drv_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_unf_q  <= rx_unf_d;
      irq_q     <= irq_d;
      rd_hold_q <= rd_hold_d;
    end
  end

  assign bus_en = drv_q & mem_io & io_rd & (sel_rx | sel_st);

  tristate_buffer #(.W(8)) u_bus_drv (.din(rd_hold_q), .en(bus_en), .dout(bus));

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller; a released bus reads 8'hFF via pullups.
module tb_io_port_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr_bus = 8'h00;
  logic       mem_io = 1'b0, io_wr = 1'b0, io_rd = 1'b0;
  logic [7:0] tb_bus = 8'h00;
  logic       tb_drv = 1'b0;
  wire  [7:0] bus;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready, irq;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] BUS_Z = 8'hFF;

  assign bus = tb_drv ? tb_bus : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus[g]);
  end

  always #5 clk = ~clk;

  io_port_controller #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .reset(reset), .addr_bus(addr_bus), .mem_io(mem_io),
    .io_wr(io_wr), .io_rd(io_rd), .bus(bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  typedef struct {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic       chk;
    string      nm;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    addr_bus = a; tb_bus = d; tb_drv = 1'b1; mem_io = 1'b1; io_wr = 1'b1;
    tick(); tick();
    io_wr = 1'b0; tb_drv = 1'b0; mem_io = 1'b0;
    tick();
  endtask

  task automatic cpu_rd(input logic [7:0] a, input int hold, output logic [7:0] d);
    addr_bus = a; mem_io = 1'b1; io_rd = 1'b1;
    #1 chk("bus_z_in_pulse_cycle", bus, BUS_Z);
    tick();
    d = bus;
    repeat (hold - 1) tick();
    io_rd = 1'b0;
    #1 chk("bus_z_after_rd_fall", bus, BUS_Z);
    mem_io = 1'b0;
    tick();
  endtask

  logic [7:0] d;

  initial begin
    // Reset state
    #1;
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_bus", bus, BUS_Z);
    chk("rst_tx_data", tx_data, 8'h00);
    tick(); tick();
    reset = 1'b0;
    tick();

    // TX path
    cpu_wr(8'h00, 8'hA5);
    cpu_wr(8'h00, 8'h3C);
    chk("tx_valid_after_wr", {7'b0, tx_valid}, 8'h01);
    chk("tx_head_a5", tx_data, 8'hA5);
    tx_ready = 1'b1;
    tick();
    chk("tx_head_3c", tx_data, 8'h3C);
    tick();
    chk("tx_valid_drained", {7'b0, tx_valid}, 8'h00);
    tx_ready = 1'b0;

    // TX overflow and flag clear, from the vector table
    for (int i = 0; i < 9; i++) vt[i] = '{1'b0, 8'h00, 8'h10 + 8'(i), 1'b0, "tx_fill"};
    vt[9]  = '{1'b1, 8'h02, 8'hA4, 1'b1, "status_ovf"};
    vt[10] = '{1'b0, 8'h02, 8'h5A, 1'b0, "status_clear"};
    vt[11] = '{1'b1, 8'h02, 8'h24, 1'b1, "status_cleared"};
    for (int i = 0; i < 12; i++) begin
      if (vt[i].rd) begin
        cpu_rd(vt[i].addr, 2, d);
        if (vt[i].chk) chk(vt[i].nm, d, vt[i].data);
      end else begin
        cpu_wr(vt[i].addr, vt[i].data);
      end
    end
    chk("tx_head_after_ovf", tx_data, 8'h10);
    chk("irq_after_clear", {7'b0, irq}, 8'h00);

    // RX path, strobe held 3 clk
    rx_valid = 1'b1; rx_data = 8'h11;
    tick();
    rx_data = 8'h22;
    tick();
    rx_valid = 1'b0;
    chk("irq_rx_nonempty", {7'b0, irq}, 8'h01);
    cpu_rd(8'h01, 3, d);
    chk("rx_read_11", d, 8'h11);
    cpu_rd(8'h01, 3, d);
    chk("rx_read_22", d, 8'h22);
    tick();
    chk("irq_rx_empty", {7'b0, irq}, 8'h00);

    // RX full then underflow
    rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_data = 8'h40 + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    chk("rx_ready_full", {7'b0, rx_ready}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cpu_rd(8'h01, 2, d);
      chk("rx_read_seq", d, 8'h40 + 8'(i));
    end
    chk("irq_before_unf", {7'b0, irq}, 8'h00);
    cpu_rd(8'h01, 2, d);
    chk("rx_read_empty", d, 8'h00);
    chk("irq_unf", {7'b0, irq}, 8'h01);
    cpu_rd(8'h02, 2, d);
    chk("status_unf", d, 8'h64);
    cpu_wr(8'h02, 8'h00);
    chk("irq_unf_cleared", {7'b0, irq}, 8'h00);

    // Simultaneous push/pop on a full TX FIFO
    addr_bus = 8'h00; tb_bus = 8'h99; tb_drv = 1'b1; mem_io = 1'b1; io_wr = 1'b1; tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("tx_head_after_pushpop", tx_data, 8'h11);
    tick();
    io_wr = 1'b0; tb_drv = 1'b0; mem_io = 1'b0;
    tick();
    cpu_rd(8'h02, 2, d);
    chk("status_pushpop_full", d, 8'h24);

    // mem_io low: strobes ignored
    addr_bus = 8'h00; tb_bus = 8'h77; tb_drv = 1'b1; io_wr = 1'b1;
    tick(); tick();
    io_wr = 1'b0; tb_drv = 1'b0;
    tick();
    cpu_rd(8'h02, 2, d);
    chk("status_memio_low_wr", d, 8'h24);
    addr_bus = 8'h02; io_rd = 1'b1;
    tick(); tick();
    chk("bus_z_memio_low_rd", bus, BUS_Z);
    io_rd = 1'b0;
    tick();

    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("tx_drain", tx_data, (i < 7) ? 8'h11 + 8'(i) : 8'h99);
      tick();
    end
    tx_ready = 1'b0;
    chk("tx_valid_after_drain", {7'b0, tx_valid}, 8'h00);

    // Reset in the middle of an RX read
    cpu_wr(8'h00, 8'h42);
    rx_valid = 1'b1; rx_data = 8'h77;
    tick();
    rx_valid = 1'b0;
    tick();
    addr_bus = 8'h01; mem_io = 1'b1; io_rd = 1'b1;
    tick();
    chk("bus_before_reset", bus, 8'h77);
    #3 reset = 1'b1;
    #1;
    chk("midrst_bus", bus, BUS_Z);
    chk("midrst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("midrst_rx_ready", {7'b0, rx_ready}, 8'h01);
    chk("midrst_irq", {7'b0, irq}, 8'h00);
    chk("midrst_tx_data", tx_data, 8'h00);
    io_rd = 1'b0; mem_io = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    cpu_rd(8'h02, 2, d);
    chk("status_after_reset", d, 8'h14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
